spi_adc_ctrl: RTL and testbench

SPI_ADC_CTRL -- requirements
Module: spi_adc_ctrl

---
 rtl/spi_adc_ctrl_pkg.sv | 24 ++
 rtl/spi_adc_ctrl_if.sv | 24 ++
 rtl/spi_adc_ctrl_sync_2ff.sv | 22 ++
 rtl/spi_adc_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_spi_adc_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_adc_ctrl_pkg.sv
// Shared constants and FSM state type for the SPI-attached ADC controller.
package spi_adc_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STREAM = 8'h03;

  localparam logic [7:0] REG_CTRL   = 8'd0;
  localparam logic [7:0] REG_DECIM  = 8'd1;
  localparam logic [7:0] REG_GAIN   = 8'd2;
  localparam logic [7:0] REG_STATUS = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RTX,
    S_COUNT,
    S_SWAIT,
    S_SHI,
    S_SLO
  } state_t;

endpackage

// File: rtl/spi_adc_ctrl_if.sv
// Byte/sample stream handshakes between the controller, the SPI slave core and the ADC.
interface spi_adc_ctrl_if #(
  parameter int SAMPLE_W = 12
);
  logic                rx_valid;
  logic [7:0]          rx_data;
  logic                rx_ready;
  logic                tx_valid;
  logic [7:0]          tx_data;
  logic                tx_ready;
  logic                adc_valid;
  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_ready;

  modport slave (
    input  rx_valid, rx_data, tx_ready, adc_valid, adc_data,
    output rx_ready, tx_valid, tx_data, adc_ready
  );

  modport master (
    output rx_valid, rx_data, tx_ready, adc_valid, adc_data,
    input  rx_ready, tx_valid, tx_data, adc_ready
  );
endinterface

// File: rtl/spi_adc_ctrl_sync_2ff.sv
// Two-flop synchronizer for an active-low level that idles high.
module sync_2ff (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/spi_adc_ctrl.sv
// Opcode-driven register file and ADC sample streamer behind an SPI slave byte interface.
module spi_adc_ctrl
  import spi_adc_pkg::*;
#(
  parameter int NREG     = 4,
  parameter int SAMPLE_W = 12
) (
  input  logic            clk_clk,
  input  logic            reset_reset_n,
  input  logic            spi_nss,
  spi_adc_ctrl_if.slave   bus,
  output logic            cfg_adc_en,
  output logic [7:0]      cfg_decim,
  output logic [7:0]      cfg_gain,
  output logic            busy
);
  localparam logic [7:0] NREG_B = 8'(NREG);

  state_t        r_state;
  logic          r_is_read;
  logic [7:0]    r_addr;
  logic          r_adc_en;
  logic [7:0]    r_decim;
  logic [7:0]    r_gain;
  logic          r_bad_op;
  logic          r_bad_addr;
  logic [8:0]    r_cnt;
  logic [15:0]   r_sample;
  logic          r_rx_ready;
  logic          r_tx_valid;
  logic [7:0]    r_tx_data;
  logic          r_adc_ready;
  logic          r_busy;
  logic          r_nss_prev;

  logic                w_nss_sync;
  logic                w_abort;
  logic                w_rx_fire;
  logic                w_tx_fire;
  logic                w_adc_fire;
  logic                w_rx_addr_ok;
  logic                w_wr_addr_ok;
  logic [7:0]          w_rd_data;
  logic [SAMPLE_W-1:0] w_adc_sample;

  sync_2ff u_nss_sync (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .i_d           (spi_nss),
    .o_q           (w_nss_sync)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) r_nss_prev <= 1'b1;
    else                r_nss_prev <= w_nss_sync;
  end

  assign w_abort      = w_nss_sync & ~r_nss_prev;
  assign w_rx_fire    = bus.rx_valid & r_rx_ready;
  assign w_tx_fire    = r_tx_valid & bus.tx_ready;
  assign w_adc_fire   = bus.adc_valid & r_adc_ready;
  assign w_rx_addr_ok = bus.rx_data < NREG_B;
  assign w_wr_addr_ok = r_addr < NREG_B;
  assign w_adc_sample = bus.adc_data;

  // Read data is looked up from the address byte as it arrives so tx_data is ready on the next edge.
  always_comb begin
    w_rd_data = '0;
    if (w_rx_addr_ok) begin
      case (bus.rx_data)
        REG_CTRL:   w_rd_data = {7'b0, r_adc_en};
        REG_DECIM:  w_rd_data = r_decim;
        REG_GAIN:   w_rd_data = r_gain;
        REG_STATUS: w_rd_data = {6'b0, r_bad_addr, r_bad_op};
        default:    w_rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_state     <= S_IDLE;
      r_is_read   <= 1'b0;
      r_addr      <= '0;
      r_adc_en    <= 1'b0;
      r_decim     <= '0;
      r_gain      <= '0;
      r_bad_op    <= 1'b0;
      r_bad_addr  <= 1'b0;
      r_cnt       <= '0;
      r_sample    <= '0;
      r_rx_ready  <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_adc_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_abort) begin
      // Frame end overrides any transfer on this edge; configuration registers are kept.
      r_state     <= S_IDLE;
      r_rx_ready  <= 1'b1;
      r_tx_valid  <= 1'b0;
      r_adc_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_rx_ready <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_rx_fire) begin
            if (bus.rx_data == OP_WRITE || bus.rx_data == OP_READ) begin
              r_is_read <= (bus.rx_data == OP_READ);
              r_state   <= S_ADDR;
              r_busy    <= 1'b1;
            end else if (bus.rx_data == OP_STREAM) begin
              r_state <= S_COUNT;
              r_busy  <= 1'b1;
            end else begin
              r_bad_op <= 1'b1;
            end
          end
        end
        S_ADDR: begin
          if (w_rx_fire) begin
            r_addr <= bus.rx_data;
            if (r_is_read) begin
              r_state    <= S_RTX;
              r_rx_ready <= 1'b0;
              r_tx_valid <= 1'b1;
              r_tx_data  <= w_rd_data;
              if (!w_rx_addr_ok) r_bad_addr <= 1'b1;
            end else begin
              r_state <= S_WDATA;
            end
          end
        end
        S_WDATA: begin
          if (w_rx_fire) begin
            if (!w_wr_addr_ok) begin
              r_bad_addr <= 1'b1;
            end else begin
              case (r_addr)
                REG_CTRL:   r_adc_en <= bus.rx_data[0];
                REG_DECIM:  r_decim  <= bus.rx_data;
                REG_GAIN:   r_gain   <= bus.rx_data;
                REG_STATUS: begin
                  r_bad_op   <= 1'b0;
                  r_bad_addr <= 1'b0;
                end
                default: ;
              endcase
            end
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_RTX: begin
          r_rx_ready <= 1'b0;
          if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
          end
        end
        S_COUNT: begin
          if (w_rx_fire) begin
            r_cnt       <= (bus.rx_data == 8'd0) ? 9'd256 : {1'b0, bus.rx_data};
            r_state     <= S_SWAIT;
            r_adc_ready <= r_adc_en;
          end
        end
        S_SWAIT: begin
          r_adc_ready <= r_adc_en;
          if (w_adc_fire) begin
            r_sample    <= 16'(w_adc_sample);
            r_tx_data   <= 8'(16'(w_adc_sample) >> 8);
            r_tx_valid  <= 1'b1;
            r_adc_ready <= 1'b0;
            r_state     <= S_SHI;
          end
        end
        S_SHI: begin
          if (w_tx_fire) begin
            r_tx_data <= r_sample[7:0];
            r_state   <= S_SLO;
          end
        end
        S_SLO: begin
          if (w_tx_fire) begin
            r_tx_valid <= 1'b0;
            r_cnt      <= r_cnt - 9'd1;
            if (r_cnt == 9'd1) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end else begin
              r_state     <= S_SWAIT;
              r_adc_ready <= r_adc_en;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = r_rx_ready;
  assign bus.tx_valid  = r_tx_valid;
  assign bus.tx_data   = r_tx_data;
  assign bus.adc_ready = r_adc_ready;
  assign cfg_adc_en    = r_adc_en;
  assign cfg_decim     = r_decim;
  assign cfg_gain      = r_gain;
  assign busy          = r_busy;

endmodule

// File: tb/tb_spi_adc_ctrl.sv
// Directed self-checking bench for spi_adc_ctrl: register access, streaming, abort and reset.
module tb_spi_adc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic nss;
  logic cfg_adc_en;
  logic [7:0] cfg_decim;
  logic [7:0] cfg_gain;
  logic busy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  spi_adc_ctrl_if #(.SAMPLE_W(12)) bus ();

  spi_adc_ctrl #(.NREG(4), .SAMPLE_W(12)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .spi_nss       (nss),
    .bus           (bus),
    .cfg_adc_en    (cfg_adc_en),
    .cfg_decim     (cfg_decim),
    .cfg_gain      (cfg_gain),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic rx_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.rx_ready) begin
      chk("rx_timeout", 32'(bus.rx_ready), 32'd1);
      bus.rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.rx_valid = 1'b0;
  endtask

  task automatic tx_byte(output logic [7:0] b, input bit stall);
    int n = 0;
    b = '0;
    @(negedge clk);
    while (!bus.tx_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.tx_valid) begin
      chk("tx_timeout", 32'(bus.tx_valid), 32'd1);
      return;
    end
    if (stall) repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.tx_ready = 1'b1;
    b = bus.tx_data;
    @(posedge clk);
    #1 bus.tx_ready = 1'b0;
  endtask

  task automatic adc_sample(input logic [11:0] s);
    int n = 0;
    @(negedge clk);
    bus.adc_valid = 1'b1;
    bus.adc_data  = s;
    while (!bus.adc_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.adc_ready) begin
      chk("adc_timeout", 32'(bus.adc_ready), 32'd1);
      bus.adc_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 bus.adc_valid = 1'b0;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    rx_byte(8'h01);
    rx_byte(a);
    rx_byte(d);
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    rx_byte(8'h02);
    rx_byte(a);
    tx_byte(d, 1'b0);
  endtask

  logic [7:0] b;
  logic [11:0] samp [3] = '{12'h111, 12'h2A5, 12'h3FF};
  int unsigned n_tx;
  int unsigned n_adc;
  int unsigned n_wait;

  initial begin
    rst_n         = 1'b0;
    nss           = 1'b1;
    bus.rx_valid  = 1'b0;
    bus.rx_data   = '0;
    bus.tx_ready  = 1'b0;
    bus.adc_valid = 1'b0;
    bus.adc_data  = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_adc_ready", 32'(bus.adc_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst_cfg", 32'({cfg_adc_en, cfg_decim, cfg_gain}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_after_rst", 32'(bus.rx_ready), 32'd1);

    // Stream with ADC disabled parks in SWAIT until aborted
    nss = 1'b0;
    repeat (3) @(negedge clk);
    rx_byte(8'h03);
    rx_byte(8'h01);
    repeat (6) @(negedge clk);
    chk("dis_adc_ready", 32'(bus.adc_ready), 32'd0);
    chk("dis_busy", 32'(busy), 32'd1);
    nss = 1'b1;
    repeat (4) @(negedge clk);
    chk("dis_abort_busy", 32'(busy), 32'd0);
    chk("dis_abort_rx_ready", 32'(bus.rx_ready), 32'd1);

    // Write DECIM then read it back
    write_reg(8'h01, 8'h5A);
    chk("decim_after_write", 32'(cfg_decim), 32'h5A);
    rx_byte(8'h02);
    rx_byte(8'h01);
    chk("rd_tx_valid_next", 32'(bus.tx_valid), 32'd1);
    chk("rd_tx_data_next", 32'(bus.tx_data), 32'h5A);
    tx_byte(b, 1'b0);
    chk("rd_decim", 32'(b), 32'h5A);

    write_reg(8'h00, 8'hFF);
    write_reg(8'h02, 8'h33);
    chk("cfg_adc_en", 32'(cfg_adc_en), 32'd1);
    chk("cfg_gain", 32'(cfg_gain), 32'h33);
    read_reg(8'h00, b);
    chk("rd_ctrl_masked", 32'(b), 32'h01);
    read_reg(8'h02, b);
    chk("rd_gain", 32'(b), 32'h33);

    // Two-sample stream with a stalling sink
    rx_byte(8'h03);
    rx_byte(8'h02);
    adc_sample(12'hABC);
    tx_byte(b, 1'b1);
    chk("s0_hi", 32'(b), 32'h0A);
    tx_byte(b, 1'b1);
    chk("s0_lo", 32'(b), 32'hBC);
    adc_sample(12'h123);
    tx_byte(b, 1'b1);
    chk("s1_hi", 32'(b), 32'h01);
    tx_byte(b, 1'b1);
    chk("s1_lo", 32'(b), 32'h23);
    @(negedge clk);
    chk("stream_done_busy", 32'(busy), 32'd0);

    // Bad opcode, bad address, status read and clear
    rx_byte(8'h7E);
    chk("badop_busy", 32'(busy), 32'd0);
    read_reg(8'h09, b);
    chk("rd_bad_addr", 32'(b), 32'h00);
    read_reg(8'h03, b);
    chk("status_sticky", 32'(b), 32'h03);
    write_reg(8'h03, 8'h00);
    read_reg(8'h03, b);
    chk("status_cleared", 32'(b), 32'h00);
    write_reg(8'h05, 8'h77);
    read_reg(8'h03, b);
    chk("status_bad_wr", 32'(b), 32'h02);
    chk("bad_wr_no_effect", 32'({cfg_decim, cfg_gain}), 32'h5A33);

    // Count 0 streams 256 samples with continuous source and sink
    bus.adc_valid = 1'b1;
    bus.adc_data  = 12'h5C3;
    bus.tx_ready  = 1'b1;
    rx_byte(8'h03);
    rx_byte(8'h00);
    n_tx  = 0;
    n_adc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (bus.tx_valid) n_tx++;
      if (bus.adc_ready) n_adc++;
      if (!busy) break;
    end
    bus.adc_valid = 1'b0;
    bus.tx_ready  = 1'b0;
    chk("n256_tx_bytes", n_tx, 32'd512);
    chk("n256_adc_hs", n_adc, 32'd256);
    chk("n256_busy_end", 32'(busy), 32'd0);

    // Abort mid-stream with a byte pending
    nss = 1'b0;
    repeat (3) @(negedge clk);
    rx_byte(8'h03);
    rx_byte(8'h05);
    for (int k = 0; k < 3; k++) begin
      adc_sample(samp[k]);
      tx_byte(b, 1'b0);
      chk("ab_hi", 32'(b), 32'(samp[k] >> 8));
      tx_byte(b, 1'b0);
      chk("ab_lo", 32'(b), 32'(samp[k] & 12'h0FF));
    end
    adc_sample(12'h456);
    @(negedge clk);
    chk("ab_pending_valid", 32'(bus.tx_valid), 32'd1);
    chk("ab_pending_data", 32'(bus.tx_data), 32'h04);
    nss = 1'b1;
    n_wait = 0;
    while (bus.tx_valid && n_wait < 4) begin
      @(negedge clk);
      n_wait++;
    end
    chk("ab_tx_dropped", 32'(bus.tx_valid), 32'd0);
    repeat (2) @(negedge clk);
    chk("ab_busy", 32'(busy), 32'd0);
    read_reg(8'h02, b);
    chk("ab_rd_gain", 32'(b), 32'h33);

    // Reset while SHI holds a byte
    rx_byte(8'h03);
    rx_byte(8'h01);
    adc_sample(12'hFFF);
    @(negedge clk);
    chk("rst_shi_valid", 32'(bus.tx_valid), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_rx_ready", 32'(bus.rx_ready), 32'd0);
    chk("rst2_tx_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst2_adc_ready", 32'(bus.adc_ready), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_tx_data", 32'(bus.tx_data), 32'h00);
    chk("rst2_cfg", 32'({cfg_adc_en, cfg_decim, cfg_gain}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_rx_ready_rise", 32'(bus.rx_ready), 32'd1);
    read_reg(8'h01, b);
    chk("rst2_rd_decim", 32'(b), 32'h00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
